// File: rtl/pow_result_fifo.sv
// pow_result_fifo: first-word-fall-through result buffer behind the x^8 power
// pipeline. Upstream cannot be stalled, so words arriving while the buffer is
// full are dropped, and each drop is recorded in a sticky overflow flag.
// Optional feature macro: POW_FIFO_DROP_CNT_EN adds a saturating 8-bit
// counter of dropped words. Without the macro, o_drop_cnt is tied to zero.
module pow_result_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_ready,
    input  logic                     i_clr_ovf,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              push, pop, drop;

    // Status flags come only from the registered count, so o_valid never
    // depends combinationally on i_valid or i_ready.
    assign o_count    = count_q;
    assign o_full     = (count_q == CW'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_valid    = ~o_empty;
    assign o_data     = mem_q[rd_ptr_q];
    assign o_overflow = ovf_q;

    // Handshake decode plus next-state for the pointers, the count and the flag.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        pop      = o_valid & i_ready;
        push     = i_valid & (~o_full | pop);
        drop     = i_valid & ~push;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ovf_d    = ovf_q;
        if (i_clr_ovf) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    // Control state register. Reset empties the buffer asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples values from before the edge no matter how the blocks are ordered.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write port. Each accepted word is written at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The zero count already marks
        // every entry invalid, and leaving the reset off lets this map onto RAM.
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

`ifdef POW_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter. A drop in a clearing cycle counts as the first new drop.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_clr_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pow_result_fifo.sv
// Testbench for pow_result_fifo. Directed scenarios are followed by a long
// random run. The reference model is an occupancy count plus a queue of the
// words the buffer must deliver. A separate monitor compares the DUT with
// that model on every falling edge.
module tb_pow_result_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid, i_ready, i_clr_ovf;
    logic [DATA_W-1:0] i_data;
    logic              o_valid, o_full, o_empty, o_overflow;
    logic [DATA_W-1:0] o_data;
    logic [3:0]        o_count;
    logic [7:0]        o_drop_cnt;

    pow_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .i_clr_ovf  (i_clr_ovf),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DATA_W-1:0] sb_q[$];
    int                mdl_cnt   = 0;
    bit                mdl_ovf   = 0;
    int                mdl_drops = 0;
    bit                mon_en    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_drop_cnt();
`ifdef POW_FIFO_DROP_CNT_EN
        return (mdl_drops > 255) ? 8'd255 : 8'(mdl_drops);
`else
        return 8'd0;
`endif
    endfunction

    // Drive one clock cycle of inputs and advance the model at the rising edge.
    // The task is entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
        bit pop_m, push_m, drop_m;
        i_valid = v; i_data = d; i_ready = r; i_clr_ovf = c;
        pop_m  = (mdl_cnt > 0) && r;
        push_m = v && ((mdl_cnt < DEPTH) || pop_m);
        drop_m = v && !push_m;
        @(posedge clk);
        if (push_m) sb_q.push_back(d);
        mdl_cnt = mdl_cnt + int'(push_m) - int'(pop_m);
        if (c) begin
            mdl_ovf   = drop_m;
            mdl_drops = int'(drop_m);
        end else if (drop_m) begin
            mdl_ovf   = 1;
            mdl_drops = mdl_drops + 1;
        end
        #1;
    endtask

    // Monitor: compare the status outputs every cycle, compare the head word,
    // and retire a scoreboard entry whenever a transfer happens.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count",    64'(o_count),    64'(mdl_cnt));
            check("valid",    64'(o_valid),    64'(mdl_cnt != 0));
            check("empty",    64'(o_empty),    64'(mdl_cnt == 0));
            check("full",     64'(o_full),     64'(mdl_cnt == DEPTH));
            check("overflow", 64'(o_overflow), 64'(mdl_ovf));
            check("drop_cnt", 64'(o_drop_cnt), 64'(exp_drop_cnt()));
            if (o_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    check("head_data", o_data, sb_q[0]);
                    if (i_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0; i_data = '0;
        #12;
        check("rst_valid",    64'(o_valid),    64'd0);
        check("rst_count",    64'(o_count),    64'd0);
        check("rst_empty",    64'(o_empty),    64'd1);
        check("rst_full",     64'(o_full),     64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        check("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Three words in with no consumer, then drain them in order.
        cycle(1'b1, 64'h1, 1'b0, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b0);
        cycle(1'b1, 64'h3, 1'b0, 1'b0);
        check("basic_count", 64'(o_count), 64'd3);
        check("basic_head",  o_data,       64'h1);
        check("basic_valid", 64'(o_valid), 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("basic_empty", 64'(o_empty), 64'd1);

        // Fill, then offer a ninth word that must be dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);
        check("ovf_full",  64'(o_full),     64'd1);
        check("ovf_flag",  64'(o_overflow), 64'd1);
`ifdef POW_FIFO_DROP_CNT_EN
        check("ovf_drops", 64'(o_drop_cnt), 64'd1);
`else
        check("ovf_drops", 64'(o_drop_cnt), 64'd0);
`endif
        drain();
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(o_overflow), 64'd0);

        // Full with a simultaneous push and pop, across pointer wrap.
        pat = 64'h1000;
        for (int i = 0; i < DEPTH; i++) begin cycle(1'b1, pat, 1'b0, 1'b0); pat++; end
        for (int i = 0; i < 20; i++) begin cycle(1'b1, pat, 1'b1, 1'b0); pat++; end
        check("stream_count", 64'(o_count),    64'd8);
        check("stream_ovf",   64'(o_overflow), 64'd0);
        drain();

        // Saturate the drop counter, then clear it in a cycle that also drops a word.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'h2000 + 64'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 64'hBAD, 1'b0, 1'b0);
`ifdef POW_FIFO_DROP_CNT_EN
        check("sat_drops", 64'(o_drop_cnt), 64'd255);
`else
        check("sat_drops", 64'(o_drop_cnt), 64'd0);
`endif
        cycle(1'b1, 64'hBAD, 1'b0, 1'b1);
        check("clr_drop_ovf", 64'(o_overflow), 64'd1);
`ifdef POW_FIFO_DROP_CNT_EN
        check("clr_drop_cnt", 64'(o_drop_cnt), 64'd1);
`else
        check("clr_drop_cnt", 64'(o_drop_cnt), 64'd0);
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        drain();

        // Assert reset asynchronously in the middle of a cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h3000 + 64'(i), 1'b0, 1'b0);
        #2;
        i_valid = 1'b0; i_ready = 1'b0;
        reset = 1'b0;
        sb_q.delete(); mdl_cnt = 0; mdl_ovf = 0; mdl_drops = 0;
        #1;
        check("async_valid", 64'(o_valid), 64'd0);
        check("async_count", 64'(o_count), 64'd0);
        check("async_empty", 64'(o_empty), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        cycle(1'b1, 64'hA5, 1'b0, 1'b0);
        check("post_rst_valid", 64'(o_valid), 64'd1);
        check("post_rst_data",  o_data,       64'hA5);
        drain();

        // Random traffic: 50% valid, 50% ready, occasional overflow clear.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
        end
        drain();
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
